toy_commit_mc: RTL and testbench

- Parametrised N-channel commit/retire stage of the toy scalar core; successor to the fixed 4-unit commit logic.
- Takes per-channel commit requests from the execution units in program order, with the lowest index being the oldest.
- Picks one trap source (precise exception, interrupt or single-step) and registers it into a trap request that is held until the trap controller accepts it.
- Tracks latest retired PC, pending jump target and an instret counter; blocks all retirement while a trap is outstanding.

---
 rtl/toy_commit_mc.sv | 172 +++++++++++++++++
 tb/tb_toy_commit_mc.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/toy_commit_mc.sv
// N-channel commit/retire stage: grants in-order retirement, picks one trap source and
// holds a registered trap request until accepted. Retire grants are combinational; trap outputs 1-cycle registered.
module toy_commit_mc #(
    parameter int NUM_CH     = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            ch_commit_en,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_pc,
    input  logic [NUM_CH-1:0]            ch_exc_en,
    input  logic [NUM_CH*32-1:0]         ch_exc_cause,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_exc_tval,
    input  logic                         jb_update_en,
    input  logic [ADDR_WIDTH-1:0]        jb_pc_val,
    input  logic                         irq_vld,
    input  logic [31:0]                  irq_cause,
    input  logic                         step_en,
    output logic [NUM_CH-1:0]            retire_en,
    output logic                         commit_block,
    output logic                         trap_vld,
    output logic [ADDR_WIDTH-1:0]        trap_pc,
    output logic [31:0]                  trap_cause,
    output logic [ADDR_WIDTH-1:0]        trap_tval,
    input  logic                         trap_rdy,
    output logic [ADDR_WIDTH-1:0]        latest_retire_pc,
    output logic [CNT_WIDTH-1:0]         retire_cnt
);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic                    trap_vld_q, trap_vld_d;
    logic [ADDR_WIDTH-1:0]   trap_pc_q, trap_pc_d;
    logic [31:0]             trap_cause_q, trap_cause_d;
    logic [ADDR_WIDTH-1:0]   trap_tval_q, trap_tval_d;
    logic [ADDR_WIDTH-1:0]   latest_pc_q, latest_pc_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    jb_vld_q, jb_vld_d;
    logic [ADDR_WIDTH-1:0]   jb_pc_q, jb_pc_d;

    logic                    exc_found;
    logic [ADDR_WIDTH-1:0]   exc_pc;
    logic [31:0]             exc_cause;
    logic [ADDR_WIDTH-1:0]   exc_tval;
    logic [NUM_CH-1:0]       ret;
    logic                    any_ret;
    logic [CNT_WIDTH-1:0]    ret_num;
    logic [ADDR_WIDTH-1:0]   hi_pc;
    logic [ADDR_WIDTH-1:0]   next_pc;
    logic                    jb_take;

    // Oldest excepting channel wins; it and everything younger is suppressed.
    always_comb begin
        exc_found = 1'b0;
        exc_pc    = '0;
        exc_cause = '0;
        exc_tval  = '0;
        ret       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (state_q == IDLE && !exc_found) begin
                if (ch_commit_en[i] && ch_exc_en[i]) begin
                    exc_found = 1'b1;
                    exc_pc    = ch_pc[i*ADDR_WIDTH +: ADDR_WIDTH];
                    exc_cause = ch_exc_cause[i*32 +: 32];
                    exc_tval  = ch_exc_tval[i*ADDR_WIDTH +: ADDR_WIDTH];
                end else begin
                    ret[i] = ch_commit_en[i];
                end
            end
        end
    end

    always_comb begin
        ret_num = '0;
        hi_pc   = latest_pc_q;
        for (int j = 0; j < NUM_CH; j++) begin
            if (ret[j]) begin
                ret_num = ret_num + CNT_WIDTH'(1);
                hi_pc   = ch_pc[j*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
        any_ret = |ret;
        jb_take = jb_update_en && any_ret;
        if (jb_take)
            next_pc = jb_pc_val;
        else if (!any_ret && jb_vld_q)
            next_pc = jb_pc_q;
        else
            next_pc = hi_pc + ADDR_WIDTH'(4);
    end

    always_comb begin
        state_d      = state_q;
        trap_vld_d   = trap_vld_q;
        trap_pc_d    = trap_pc_q;
        trap_cause_d = trap_cause_q;
        trap_tval_d  = trap_tval_q;
        latest_pc_d  = any_ret ? hi_pc : latest_pc_q;
        cnt_d        = cnt_q + ret_num;
        jb_vld_d     = jb_vld_q;
        jb_pc_d      = jb_pc_q;
        if (jb_take) begin
            jb_vld_d = 1'b1;
            jb_pc_d  = jb_pc_val;
        end else if (any_ret) begin
            jb_vld_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (exc_found || irq_vld || (step_en && any_ret)) begin
                    state_d     = HOLD;
                    trap_vld_d  = 1'b1;
                    trap_tval_d = '0;
                    trap_pc_d   = next_pc;
                    if (exc_found) begin
                        trap_pc_d    = exc_pc;
                        trap_cause_d = exc_cause;
                        trap_tval_d  = exc_tval;
                    end else if (irq_vld) begin
                        trap_cause_d = irq_cause;
                    end else begin
                        trap_cause_d = 32'h3;
                    end
                end
            end
            HOLD: begin
                if (trap_vld_q && trap_rdy) begin
                    state_d    = IDLE;
                    trap_vld_d = 1'b0;
                    jb_vld_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            trap_vld_q   <= 1'b0;
            trap_pc_q    <= '0;
            trap_cause_q <= '0;
            trap_tval_q  <= '0;
            latest_pc_q  <= '0;
            cnt_q        <= '0;
            jb_vld_q     <= 1'b0;
            jb_pc_q      <= '0;
        end else begin
            state_q      <= state_d;
            trap_vld_q   <= trap_vld_d;
            trap_pc_q    <= trap_pc_d;
            trap_cause_q <= trap_cause_d;
            trap_tval_q  <= trap_tval_d;
            latest_pc_q  <= latest_pc_d;
            cnt_q        <= cnt_d;
            jb_vld_q     <= jb_vld_d;
            jb_pc_q      <= jb_pc_d;
        end
    end

    assign retire_en        = ret;
    assign commit_block     = (state_q == HOLD);
    assign trap_vld         = trap_vld_q;
    assign trap_pc          = trap_pc_q;
    assign trap_cause       = trap_cause_q;
    assign trap_tval        = trap_tval_q;
    assign latest_retire_pc = latest_pc_q;
    assign retire_cnt       = cnt_q;

endmodule

// File: tb/tb_toy_commit_mc.sv
// Bench for toy_commit_mc: directed scenarios then random traffic against a behavioural model.
module tb_toy_commit_mc;
    localparam int NC = 4;
    localparam int AW = 32;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NC-1:0]     ch_commit_en;
    logic [NC*AW-1:0]  ch_pc;
    logic [NC-1:0]     ch_exc_en;
    logic [NC*32-1:0]  ch_exc_cause;
    logic [NC*AW-1:0]  ch_exc_tval;
    logic              jb_update_en;
    logic [AW-1:0]     jb_pc_val;
    logic              irq_vld;
    logic [31:0]       irq_cause;
    logic              step_en;
    logic [NC-1:0]     retire_en;
    logic              commit_block;
    logic              trap_vld;
    logic [AW-1:0]     trap_pc;
    logic [31:0]       trap_cause;
    logic [AW-1:0]     trap_tval;
    logic              trap_rdy;
    logic [AW-1:0]     latest_retire_pc;
    logic [CW-1:0]     retire_cnt;

    toy_commit_mc #(.NUM_CH(NC), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ch_commit_en(ch_commit_en), .ch_pc(ch_pc), .ch_exc_en(ch_exc_en),
        .ch_exc_cause(ch_exc_cause), .ch_exc_tval(ch_exc_tval),
        .jb_update_en(jb_update_en), .jb_pc_val(jb_pc_val),
        .irq_vld(irq_vld), .irq_cause(irq_cause), .step_en(step_en),
        .retire_en(retire_en), .commit_block(commit_block),
        .trap_vld(trap_vld), .trap_pc(trap_pc), .trap_cause(trap_cause),
        .trap_tval(trap_tval), .trap_rdy(trap_rdy),
        .latest_retire_pc(latest_retire_pc), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state (architectural view, not RTL encoding)
    bit          m_hold;
    bit          m_tv;
    int unsigned m_tpc, m_tcause, m_ttval, m_latest, m_cnt, m_jbpc;
    bit          m_jbv;
    bit [NC-1:0] m_ret;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hold = 0; m_tv = 0; m_tpc = 0; m_tcause = 0; m_ttval = 0;
        m_latest = 0; m_cnt = 0; m_jbv = 0; m_jbpc = 0;
    endtask

    task automatic clear_inputs();
        ch_commit_en = '0; ch_pc = '0; ch_exc_en = '0; ch_exc_cause = '0;
        ch_exc_tval = '0; jb_update_en = 0; jb_pc_val = '0; irq_vld = 0;
        irq_cause = '0; step_en = 0; trap_rdy = 0;
    endtask

    function automatic int unsigned pc_of(input int i);
        return ch_pc[i*AW +: AW];
    endfunction

    task automatic check_regs();
        check("trap_vld", trap_vld, m_tv);
        check("commit_block", commit_block, m_hold);
        check("trap_pc", trap_pc, m_tpc);
        check("trap_cause", trap_cause, m_tcause);
        check("trap_tval", trap_tval, m_ttval);
        check("latest_pc", latest_retire_pc, m_latest);
        check("retire_cnt", retire_cnt, m_cnt);
    endtask

    // Inputs already applied after a negedge; check, advance the model, move to next negedge.
    task automatic run_cycle();
        int e;
        int n;
        int unsigned hi, npc;
        bit jb_take;
        #1;
        e = -1;
        for (int i = 0; i < NC; i++)
            if (e < 0 && ch_commit_en[i] && ch_exc_en[i]) e = i;
        m_ret = '0;
        n = 0;
        hi = m_latest;
        if (!m_hold) begin
            for (int j = 0; j < NC; j++) begin
                if (ch_commit_en[j] && (e < 0 || j < e)) begin
                    m_ret[j] = 1; n++; hi = pc_of(j);
                end
            end
        end
        check_regs();
        check("retire_en", retire_en, m_ret);
        jb_take = !m_hold && jb_update_en && n > 0;
        if (jb_take) npc = jb_pc_val;
        else if (n == 0 && m_jbv) npc = m_jbpc;
        else npc = hi + 4;
        if (m_hold) begin
            if (trap_rdy) begin m_hold = 0; m_tv = 0; m_jbv = 0; end
        end else begin
            m_cnt = (m_cnt + n) % (1 << CW);
            if (n > 0) m_latest = hi;
            if (jb_take) begin m_jbv = 1; m_jbpc = jb_pc_val; end
            else if (n > 0) m_jbv = 0;
            if (e >= 0) begin
                m_hold = 1; m_tv = 1; m_tpc = pc_of(e);
                m_tcause = ch_exc_cause[e*32 +: 32]; m_ttval = ch_exc_tval[e*AW +: AW];
            end else if (irq_vld) begin
                m_hold = 1; m_tv = 1; m_tpc = npc; m_tcause = irq_cause; m_ttval = 0;
            end else if (step_en && n > 0) begin
                m_hold = 1; m_tv = 1; m_tpc = npc; m_tcause = 3; m_ttval = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic release_trap();
        clear_inputs();
        trap_rdy = 1;
        run_cycle();
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        model_reset();
        rst_n = 0;
        repeat (2) @(negedge clk);
        check_regs();
        rst_n = 1;

        // single retire
        ch_commit_en = 4'b0101; ch_pc[0 +: AW] = 32'h100; ch_pc[2*AW +: AW] = 32'h108;
        run_cycle();
        clear_inputs();
        check("d_latest_108", latest_retire_pc, 32'h108);
        check("d_cnt_2", retire_cnt, 2);

        // precise exception on ch2
        ch_commit_en = 4'b1111; ch_exc_en = 4'b0100;
        for (int i = 0; i < NC; i++) ch_pc[i*AW +: AW] = 32'h200 + 4*i;
        ch_exc_cause[2*32 +: 32] = 5; ch_exc_tval[2*AW +: AW] = 32'hDEAD;
        #1 check("d_exc_ret", retire_en, 4'b0011);
        run_cycle();
        clear_inputs();
        check("d_exc_vld", trap_vld, 1);
        check("d_exc_pc", trap_pc, 32'h208);
        check("d_exc_cause", trap_cause, 5);
        check("d_exc_tval", trap_tval, 32'hDEAD);
        check("d_exc_cnt", retire_cnt, 4);

        // hold stability with pressure from all channels
        for (int k = 0; k < 5; k++) begin
            ch_commit_en = 4'b1111; irq_vld = 1; step_en = 1;
            run_cycle();
        end
        check("d_hold_pc", trap_pc, 32'h208);
        release_trap();
        check("d_exit_vld", trap_vld, 0);
        check("d_exit_blk", commit_block, 0);

        // interrupt after a branch
        ch_commit_en = 4'b0010; ch_pc[AW +: AW] = 32'h300; jb_update_en = 1; jb_pc_val = 32'h400;
        run_cycle();
        clear_inputs();
        irq_vld = 1; irq_cause = 32'h8000000B;
        run_cycle();
        clear_inputs();
        check("d_irq_pc", trap_pc, 32'h400);
        check("d_irq_cause", trap_cause, 32'h8000000B);
        release_trap();

        // interrupt vs exception in the same cycle
        irq_vld = 1; irq_cause = 32'h80000007;
        ch_commit_en = 4'b0001; ch_exc_en = 4'b0001; ch_pc[0 +: AW] = 32'h500;
        ch_exc_cause[0 +: 32] = 7;
        #1 check("d_ie_ret", retire_en, 0);
        run_cycle();
        clear_inputs();
        check("d_ie_cause", trap_cause, 7);
        check("d_ie_pc", trap_pc, 32'h500);
        release_trap();

        // fill counter to 15, then step-trap on a wrapping retire
        while (m_cnt != 15) begin
            ch_commit_en = (15 - m_cnt >= 4) ? 4'b1111 : 4'((1 << (15 - m_cnt)) - 1);
            run_cycle();
            clear_inputs();
        end
        step_en = 1; ch_commit_en = 4'b0001; ch_pc[0 +: AW] = 32'h600;
        run_cycle();
        clear_inputs();
        check("d_wrap_cnt", retire_cnt, 0);
        check("d_step_vld", trap_vld, 1);
        check("d_step_pc", trap_pc, 32'h604);
        check("d_step_cause", trap_cause, 3);

        // asynchronous reset while holding
        #3 rst_n = 0;
        #1;
        model_reset();
        check("d_rst_vld", trap_vld, 0);
        check("d_rst_pc", trap_pc, 0);
        check("d_rst_cnt", retire_cnt, 0);
        check("d_rst_latest", latest_retire_pc, 0);
        @(negedge clk);
        rst_n = 1;

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            ch_commit_en = 4'($urandom);
            for (int i = 0; i < NC; i++) begin
                ch_pc[i*AW +: AW] = $urandom & 32'hFFFFFFFC;
                ch_exc_cause[i*32 +: 32] = $urandom_range(15);
                ch_exc_tval[i*AW +: AW] = $urandom;
                ch_exc_en[i] = ($urandom_range(15) == 0);
            end
            jb_update_en = ($urandom_range(3) == 0);
            jb_pc_val = $urandom;
            irq_vld = ($urandom_range(15) == 0);
            irq_cause = 32'h80000000 | $urandom_range(15);
            step_en = ($urandom_range(7) == 0);
            trap_rdy = $urandom_range(1);
            run_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end
endmodule
